controle_multiciclo: RTL and testbench

Multicycle main control FSM for the RV32I-subset core (lw, sw, beq, R-type, I-type ALU). Sequences the shared datapath (PC, IR, register file, ALU, immediate generator, single memory port) over FETCH/DECODE/EXECUTE/MEM/WB steps. It also handles a req/ready memory handshake with a timeout watchdog, and counts retired instructions. Sits beside the ID stage; takes opcode from the IR and zero from the ALU.

---
 rtl/controle_multiciclo.sv | 200 ++++++++++++++++++++
 tb/tb_controle_multiciclo.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : controle_multiciclo
// Description : Multicycle main control FSM for an RV32I subset core
//               (lw, sw, beq, R-type, I-type ALU) with memory req/ready
//               handshake, timeout watchdog and retired-instruction counter.
// Revision    : 1.0 - initial release
// ============================================================================
module controle_multiciclo #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             adr_src,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       result_src,
  output logic             reg_write,
  output logic             instr_done,
  output logic             illegal_instr,
  output logic             bus_error,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic WDOG_EN = (TIMEOUT != 0);

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    TRAP     = 4'd10
  } state_t;

  state_t            state, next_state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_state;
  logic              timeout_hit;

  // Watchdog condition: still waiting on memory in the last allowed cycle
  always_comb begin
    mem_state   = (state == FETCH) || (state == MEMREAD) || (state == MEMWRITE);
    timeout_hit = WDOG_EN && mem_state && !mem_ready && (wait_cnt == WAIT_LAST);
  end

  // Next-state and Moore/strobe decode; every strobe is forced low in reset
  always_comb begin
    next_state = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    alu_op     = 2'b00;
    result_src = 2'b00;
    reg_write  = 1'b0;
    instr_done = 1'b0;
    if (rst_n) begin
      case (state)
        FETCH: begin
          mem_req    = 1'b1;
          alu_src_b  = 2'b10;
          result_src = 2'b10;
          if (mem_ready) begin
            ir_write   = 1'b1;
            pc_write   = 1'b1;
            next_state = DECODE;
          end else if (timeout_hit) begin
            next_state = TRAP;
          end
        end
        DECODE: begin
          alu_src_a = 2'b01;
          alu_src_b = 2'b01;
          case (opcode)
            OP_LW, OP_SW: next_state = MEMADR;
            OP_R:         next_state = EXECR;
            OP_I:         next_state = EXECI;
            OP_BEQ:       next_state = BEQ;
            default:      next_state = TRAP;
          endcase
        end
        MEMADR: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          next_state = (opcode == OP_LW) ? MEMREAD : MEMWRITE;
        end
        MEMREAD: begin
          mem_req = 1'b1;
          adr_src = 1'b1;
          if (mem_ready)        next_state = MEMWB;
          else if (timeout_hit) next_state = TRAP;
        end
        MEMWB: begin
          result_src = 2'b01;
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        MEMWRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          adr_src = 1'b1;
          if (mem_ready) begin
            instr_done = 1'b1;
            next_state = FETCH;
          end else if (timeout_hit) begin
            next_state = TRAP;
          end
        end
        EXECR: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b10;
          next_state = ALUWB;
        end
        EXECI: begin
          alu_src_a  = 2'b10;
          alu_src_b  = 2'b01;
          alu_op     = 2'b10;
          next_state = ALUWB;
        end
        ALUWB: begin
          reg_write  = 1'b1;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        BEQ: begin
          alu_src_a  = 2'b10;
          alu_op     = 2'b01;
          pc_write   = zero;
          instr_done = 1'b1;
          next_state = FETCH;
        end
        default: next_state = TRAP;
      endcase
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Watchdog counter: cleared on entering a memory state, counts idle waits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if ((next_state != state) &&
                 ((next_state == FETCH) || (next_state == MEMREAD) || (next_state == MEMWRITE))) begin
      wait_cnt <= '0;
    end else if (WDOG_EN && mem_state && !mem_ready) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  // Sticky error flags, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_instr <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      if ((state == DECODE) && (next_state == TRAP)) illegal_instr <= 1'b1;
      if (timeout_hit)                               bus_error     <= 1'b1;
    end
  end

  // Retired instruction counter, wraps naturally at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          instret <= '0;
    else if (instr_done) instret <= instret + 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_controle_multiciclo.sv
`default_nettype none
// ============================================================================
// Module      : tb_controle_multiciclo
// Description : Directed self-checking bench for controle_multiciclo using a
//               scoreboard queue of expected per-cycle control outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_controle_multiciclo;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [6:0]    opcode = 7'b0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          mem_req, mem_we, adr_src, ir_write, pc_write;
  logic [1:0]    alu_src_a, alu_src_b, alu_op, result_src;
  logic          reg_write, instr_done, illegal_instr, bus_error;
  logic [CW-1:0] instret;

  controle_multiciclo #(.TIMEOUT(16), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .adr_src(adr_src), .ir_write(ir_write),
    .pc_write(pc_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .result_src(result_src), .reg_write(reg_write),
    .instr_done(instr_done), .illegal_instr(illegal_instr), .bus_error(bus_error),
    .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       req, we, adr, irw, pcw;
    logic [1:0] a, b, op, rs;
    logic       rw, done, ill, berr;
  } outs_t;

  typedef struct {
    string tag;
    outs_t v;
  } exp_t;

  typedef enum int {T_RST, T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB,
                    T_MEMWRITE, T_EXECR, T_EXECI, T_ALUWB, T_BEQ, T_TRAP} tst_e;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic exp_ill = 1'b0;
  logic exp_berr = 1'b0;

  // Reference decode table for each state
  function automatic outs_t model(input tst_e s, input logic rdy, input logic z);
    outs_t o;
    o = '0;
    case (s)
      T_FETCH:    begin o.req = 1; o.b = 2'b10; o.rs = 2'b10; o.irw = rdy; o.pcw = rdy; end
      T_DECODE:   begin o.a = 2'b01; o.b = 2'b01; end
      T_MEMADR:   begin o.a = 2'b10; o.b = 2'b01; end
      T_MEMREAD:  begin o.req = 1; o.adr = 1; end
      T_MEMWB:    begin o.rs = 2'b01; o.rw = 1; o.done = 1; end
      T_MEMWRITE: begin o.req = 1; o.we = 1; o.adr = 1; o.done = rdy; end
      T_EXECR:    begin o.a = 2'b10; o.op = 2'b10; end
      T_EXECI:    begin o.a = 2'b10; o.b = 2'b01; o.op = 2'b10; end
      T_ALUWB:    begin o.rw = 1; o.done = 1; end
      T_BEQ:      begin o.a = 2'b10; o.op = 2'b01; o.pcw = z; o.done = 1; end
      default:    o = '0;
    endcase
    if (s != T_RST) begin
      o.ill  = exp_ill;
      o.berr = exp_berr;
    end
    return o;
  endfunction

  // Pop the oldest expectation and compare against the live outputs
  task automatic check_out();
    exp_t  e;
    outs_t obs;
    e   = sb.pop_front();
    obs = '{mem_req, mem_we, adr_src, ir_write, pc_write, alu_src_a, alu_src_b,
            alu_op, result_src, reg_write, instr_done, illegal_instr, bus_error};
    checks++;
    assert (obs === e.v) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check, advance
  task automatic cyc(input string tag, input tst_e s, input logic rdy, input logic z);
    exp_t e;
    mem_ready = rdy;
    zero      = z;
    e.tag = tag;
    e.v   = model(s, rdy, z);
    sb.push_back(e);
    #1;
    check_out();
    @(negedge clk);
  endtask

  task automatic chk_cnt(input string tag, input logic [CW-1:0] exp);
    checks++;
    assert (instret === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, instret, exp);
    end
  endtask

  task automatic do_reset(input string tag);
    rst_n    = 1'b0;
    exp_ill  = 1'b0;
    exp_berr = 1'b0;
    cyc(tag, T_RST, 1'b1, 1'b0);
    chk_cnt({tag, "_cnt"}, '0);
    rst_n = 1'b1;
  endtask

  task automatic run_lw();
    opcode = 7'b0000011;
    cyc("lw_fetch", T_FETCH, 1, 0);
    cyc("lw_decode", T_DECODE, 1, 0);
    cyc("lw_memadr", T_MEMADR, 1, 0);
    cyc("lw_memread", T_MEMREAD, 1, 0);
    cyc("lw_memwb", T_MEMWB, 1, 0);
  endtask

  task automatic run_sw(input int waits);
    opcode = 7'b0100011;
    cyc("sw_fetch", T_FETCH, 1, 0);
    cyc("sw_decode", T_DECODE, 1, 0);
    cyc("sw_memadr", T_MEMADR, 1, 0);
    for (int i = 0; i < waits; i++) cyc("sw_wait", T_MEMWRITE, 0, 0);
    cyc("sw_done", T_MEMWRITE, 1, 0);
  endtask

  task automatic run_beq(input logic z);
    opcode = 7'b1100011;
    cyc("beq_fetch", T_FETCH, 1, z);
    cyc("beq_decode", T_DECODE, 1, z);
    cyc(z ? "beq_taken" : "beq_not_taken", T_BEQ, 1, z);
  endtask

  task automatic run_alu(input logic imm);
    opcode = imm ? 7'b0010011 : 7'b0110011;
    cyc("alu_fetch", T_FETCH, 1, 0);
    cyc("alu_decode", T_DECODE, 1, 0);
    cyc(imm ? "execi" : "execr", imm ? T_EXECI : T_EXECR, 1, 0);
    cyc("aluwb", T_ALUWB, 1, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

  initial begin
    do_reset("reset0");

    run_lw();
    chk_cnt("instret_lw", 4'd1);
    run_sw(3);
    chk_cnt("instret_sw", 4'd2);
    run_beq(1'b1);
    run_beq(1'b0);
    chk_cnt("instret_beq", 4'd4);
    run_alu(1'b0);
    run_alu(1'b1);
    chk_cnt("instret_alu", 4'd6);
    for (int i = 0; i < 10; i++) run_beq(1'b0);
    chk_cnt("instret_wrap", 4'd0);

    // Ready arrives on the 16th fetch cycle: transfer wins, no bus error
    opcode = 7'b0110011;
    for (int i = 0; i < 15; i++) cyc("fetch_wait", T_FETCH, 0, 0);
    cyc("fetch_ready16", T_FETCH, 1, 0);
    cyc("late_decode", T_DECODE, 1, 0);
    cyc("late_execr", T_EXECR, 1, 0);
    cyc("late_aluwb", T_ALUWB, 1, 0);
    chk_cnt("instret_late", 4'd1);

    // Illegal opcode traps and stays trapped
    opcode = 7'b1111111;
    cyc("ill_fetch", T_FETCH, 1, 0);
    cyc("ill_decode", T_DECODE, 1, 0);
    exp_ill = 1'b1;
    for (int i = 0; i < 4; i++) cyc("ill_trap", T_TRAP, 1, 0);
    chk_cnt("instret_ill", 4'd1);
    do_reset("reset_ill");
    cyc("post_ill_fetch", T_FETCH, 0, 0);

    // Fetch never acknowledged: watchdog trips after 16 cycles
    do_reset("reset_to");
    for (int i = 0; i < 16; i++) cyc("to_wait", T_FETCH, 0, 0);
    exp_berr = 1'b1;
    for (int i = 0; i < 3; i++) cyc("to_trap", T_TRAP, 1, 0);

    // Reset in the middle of a load aborts without retiring
    do_reset("reset_mid");
    opcode = 7'b0000011;
    cyc("mid_fetch", T_FETCH, 1, 0);
    cyc("mid_decode", T_DECODE, 1, 0);
    cyc("mid_memadr", T_MEMADR, 1, 0);
    cyc("mid_memread", T_MEMREAD, 0, 0);
    do_reset("reset_abort");
    cyc("abort_fetch", T_FETCH, 1, 0);
    chk_cnt("instret_abort", 4'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
